// File: rtl/adc_pkg.sv
// Shared constants, state encodings and thermometer-code helpers for the flash ADC sequencer.
package adc_pkg;

  localparam int unsigned N_CMP   = 4;
  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned SUM_W   = 6;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OSR_W   = 2;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
  localparam logic [STATE_W-1:0] ST_ACQ    = 2'd2;

  // Run configuration captured on an accepted start
  typedef struct packed {
    logic             continuous;
    logic [OSR_W-1:0] osr_log2;
  } run_cfg_t;

  function automatic logic [LEVEL_W-1:0] thermo_popcount(input logic [N_CMP-1:0] code);
    logic [LEVEL_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_CMP; i++) begin
      cnt = cnt + LEVEL_W'(code[i]);
    end
    return cnt;
  endfunction

  // Legal codes are of the form 2^k-1, i.e. (code+1) & code == 0
  function automatic logic thermo_legal(input logic [N_CMP-1:0] code);
    logic [N_CMP:0] ext;
    ext = {1'b0, code};
    return ((ext + (N_CMP+1)'(1)) & ext) == '0;
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// Result valid/ready port of the ADC sample sequencer.
interface adc_sample_sequencer_if;
  import adc_pkg::*;

  logic               res_valid;
  logic               res_ready;
  logic [SUM_W-1:0]   res_sum;
  logic [LEVEL_W-1:0] res_last;

  modport master (output res_valid, output res_sum, output res_last, input res_ready);
  modport slave  (input res_valid, input res_sum, input res_last, output res_ready);

endinterface

// File: rtl/adc_sample_sequencer_cmp_sync.sv
// Multi-flop synchroniser for the asynchronous comparator outputs.
module cmp_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adc_sample_sequencer.sv
// Flash ADC conversion sequencer: settle, paced sampling, bubble correction,
// oversampling accumulation and a valid/ready result port.
module adc_sample_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned DIV_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_CMP-1:0]       cmp_in,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic [OSR_W-1:0]       osr_log2,
  adc_sample_sequencer_if.master res,
  output logic                   busy,
  output logic                   bubble_err,
  output logic                   overrun
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);

  logic [N_CMP-1:0] cmp_s;

  cmp_sync #(.WIDTH(N_CMP), .STAGES(SYNC_STAGES)) u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  logic [STATE_W-1:0]  state_q,      state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q,    div_cnt_d;
  logic [DIV_W-1:0]    rate_div_q,   rate_div_d;
  logic [SUM_W-1:0]    acc_q,        acc_d;
  logic [CNT_W-1:0]    n_q,          n_d;
  run_cfg_t            cfg_q,        cfg_d;
  logic                res_valid_q,  res_valid_d;
  logic [SUM_W-1:0]    res_sum_q,    res_sum_d;
  logic [LEVEL_W-1:0]  res_last_q,   res_last_d;
  logic                busy_q,       busy_d;
  logic                bubble_err_q, bubble_err_d;
  logic                overrun_q,    overrun_d;

  logic [LEVEL_W-1:0]  level;
  logic                legal;
  logic [CNT_W-1:0]    n_inc;
  logic                cont_next;

  // Next-state, counters, accumulator and output register logic
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    div_cnt_d    = div_cnt_q;
    rate_div_d   = rate_div_q;
    acc_d        = acc_q;
    n_d          = n_q;
    cfg_d        = cfg_q;
    res_valid_d  = res_valid_q;
    res_sum_d    = res_sum_q;
    res_last_d   = res_last_q;
    bubble_err_d = bubble_err_q;
    overrun_d    = overrun_q;
    level        = thermo_popcount(cmp_s);
    legal        = thermo_legal(cmp_s);
    n_inc        = n_q + CNT_W'(1);
    cont_next    = cfg_q.continuous & continuous;

    if (res_valid_q && res.res_ready) res_valid_d = 1'b0;

    if (!ena) begin
      state_d      = ST_IDLE;
      settle_cnt_d = '0;
      div_cnt_d    = '0;
      acc_d        = '0;
      n_d          = '0;
      res_valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_d.continuous = continuous;
            cfg_d.osr_log2   = osr_log2;
            rate_div_d       = rate_div;
            bubble_err_d     = 1'b0;
            overrun_d        = 1'b0;
            settle_cnt_d     = '0;
            state_d          = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_W'(SETTLE_CYC - 1)) begin
            settle_cnt_d = '0;
            div_cnt_d    = '0;
            acc_d        = '0;
            n_d          = '0;
            state_d      = ST_ACQ;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
          end
        end
        ST_ACQ: begin
          if (div_cnt_q == rate_div_q) begin
            div_cnt_d = '0;
            if (!legal) bubble_err_d = 1'b1;
            if (n_inc == (CNT_W'(1) << cfg_q.osr_log2)) begin
              // Result complete: load the port if it is free or draining now
              if (!res_valid_q || res.res_ready) begin
                res_valid_d = 1'b1;
                res_sum_d   = acc_q + SUM_W'(level);
                res_last_d  = level;
              end else begin
                overrun_d = 1'b1;
              end
              acc_d            = '0;
              n_d              = '0;
              cfg_d.continuous = cont_next;
              state_d          = cont_next ? ST_ACQ : ST_IDLE;
            end else begin
              acc_d = acc_q + SUM_W'(level);
              n_d   = n_inc;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      div_cnt_q    <= '0;
      rate_div_q   <= '0;
      acc_q        <= '0;
      n_q          <= '0;
      cfg_q        <= '0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_last_q   <= '0;
      busy_q       <= 1'b0;
      bubble_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      div_cnt_q    <= div_cnt_d;
      rate_div_q   <= rate_div_d;
      acc_q        <= acc_d;
      n_q          <= n_d;
      cfg_q        <= cfg_d;
      res_valid_q  <= res_valid_d;
      res_sum_q    <= res_sum_d;
      res_last_q   <= res_last_d;
      busy_q       <= busy_d;
      bubble_err_q <= bubble_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign res.res_valid = res_valid_q;
  assign res.res_sum   = res_sum_q;
  assign res.res_last  = res_last_q;
  assign busy          = busy_q;
  assign bubble_err    = bubble_err_q;
  assign overrun       = overrun_q;

endmodule
